mips_dcache: RTL

- Parametrised write-back, write-allocate data cache between the MEM stage and the data memory block port.
- Replaces the current no-cache pass-through on the DC path. MEM drives the same word-level request signals as today.
- The cache fills and evicts 256-bit blocks over dBlkRead/dBlkWrite, and implements flush_2DC so SYS can flush and invalidate all lines.
- Associativity is 1 or 2 ways, with one LRU bit per set.

---
 rtl/mips_dcache_pkg.sv | 32 +++
 rtl/mips_dcache_if.sv | 33 +++
 rtl/mips_dcache_tag_store.sv | 82 ++++++++
 rtl/mips_dcache.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mips_dcache_pkg.sv
// Shared types and helpers for the MIPS write-back, write-allocate data cache.
package mips_dcache_pkg;

  localparam int BLOCK_BITS      = 256;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_W        = 5;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FILL,
    FLUSH_SCAN,
    FLUSH_WB,
    FLUSH_DONE
  } state_e;

  // Big-endian store merge: byte offset+k takes the k-th most significant of the low n data bytes.
  function automatic logic [31:0] merge_bytes(input logic [31:0] word, input logic [1:0] offset,
                                              input logic [1:0] size, input logic [31:0] data);
    logic [31:0] res;
    int n;
    int pos;
    res = word;
    n = (size == 2'd0) ? 4 : int'(size);
    for (int k = 0; k < 4; k++) begin
      pos = int'(offset) + k;
      if (k < n && pos < 4) res[8*(3-pos) +: 8] = data[8*(n-1-k) +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mips_dcache_if.sv
// MEM-stage request bus and data-memory block port of the data cache.
interface mips_dcache_if #(parameter int ADDR_W = 32);
  logic              read_2DC;
  logic              write_2DC;
  logic [ADDR_W-1:0] data_address_2DC;
  logic [31:0]       data_write_2DC;
  logic [1:0]        data_write_size_2DC;
  logic              flush_2DC;
  logic [31:0]       data_read_fDC;
  logic              data_valid_fDC;
  logic              flush_done_fDC;
  logic [ADDR_W-1:0] data_address_2DM;
  logic              dBlkRead;
  logic              dBlkWrite;
  logic [255:0]      block_write_2DM;
  logic [255:0]      block_read_fDM;
  logic              block_read_fDM_valid;
  logic              block_write_fDM_valid;

  modport slave (
    input  read_2DC, write_2DC, data_address_2DC, data_write_2DC, data_write_size_2DC, flush_2DC,
           block_read_fDM, block_read_fDM_valid, block_write_fDM_valid,
    output data_read_fDC, data_valid_fDC, flush_done_fDC, data_address_2DM, dBlkRead, dBlkWrite,
           block_write_2DM
  );

  modport master (
    output read_2DC, write_2DC, data_address_2DC, data_write_2DC, data_write_size_2DC, flush_2DC,
           block_read_fDM, block_read_fDM_valid, block_write_fDM_valid,
    input  data_read_fDC, data_valid_fDC, flush_done_fDC, data_address_2DM, dBlkRead, dBlkWrite,
           block_write_2DM
  );
endinterface

// File: rtl/mips_dcache_tag_store.sv
// Tag/valid/dirty/LRU state of the data cache with hit-way and victim selection.
module dcache_tag_store #(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 2,
  parameter int IDX_W    = 6,
  parameter int TAG_W    = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] lk_tag,
  input  logic             sel_way,
  input  logic             op_way,
  input  logic             op_touch,
  input  logic             op_dirty,
  input  logic             op_fill,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             op_clean,
  input  logic             op_inval,
  output logic             hit,
  output logic             hit_way,
  output logic             vict_way,
  output logic             vict_dirty,
  output logic [TAG_W-1:0] sel_tag,
  output logic             sel_dirty
);

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic                lru_q   [NUM_SETS];
  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [1:0]          v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        lru_q[s]   <= 1'b0;
      end
    end else begin
      if (op_touch) lru_q[idx] <= ~op_way;
      if (op_dirty) dirty_q[idx][op_way] <= 1'b1;
      if (op_clean) dirty_q[idx][op_way] <= 1'b0;
      if (op_fill) begin
        valid_q[idx][op_way] <= 1'b1;
        dirty_q[idx][op_way] <= 1'b0;
        lru_q[idx]           <= ~op_way;
      end
      if (op_inval) begin
        valid_q[idx][op_way] <= 1'b0;
        dirty_q[idx][op_way] <= 1'b0;
        lru_q[idx]           <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (op_fill) tag_q[idx][op_way] <= fill_tag;
  end

  // lru_q holds the least recently used way of the set.
  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == lk_tag) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
    v2 = 2'(valid_q[idx]);
    if (!v2[0])                      vict_way = 1'b0;
    else if (NUM_WAYS == 2 && !v2[1]) vict_way = 1'b1;
    else if (NUM_WAYS == 2)           vict_way = lru_q[idx];
    else                              vict_way = 1'b0;
    vict_dirty = valid_q[idx][vict_way] & dirty_q[idx][vict_way];
    sel_tag    = tag_q[idx][sel_way];
    sel_dirty  = valid_q[idx][sel_way] & dirty_q[idx][sel_way];
  end

endmodule

// File: rtl/mips_dcache.sv
// Write-back, write-allocate data cache with block refill/eviction and flush.
// Optional DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module mips_dcache
  import mips_dcache_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 2,
  parameter int ADDR_W   = 32
) (
  input  logic CLK,
  input  logic RESET,
  mips_dcache_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

  state_e                   state_q, state_n;
  logic [IDX_W-1:0]         scan_set_q;
  logic                     scan_way_q;
  logic [ADDR_W-OFFSET_W-1:0] lat_blk_q;
  logic                     vway_q;
  logic [BLOCK_BITS-1:0]    data_arr [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0] req_idx, idx;
  logic [TAG_W-1:0] req_tag, sel_tag;
  logic [2:0]       req_word;
  logic             req, hit, hit_way, vict_way, vict_dirty, sel_dirty, sel_way;
  logic             op_way, op_touch, op_dirty, op_fill, op_clean, op_inval;
  logic             hit_svc, hit_wr, fill_we, latch, scan_adv, last_line;
  logic [31:0]      cur_word, wr_word;

  assign req_idx   = bus.data_address_2DC[OFFSET_W +: IDX_W];
  assign req_tag   = bus.data_address_2DC[ADDR_W-1 -: TAG_W];
  assign req_word  = bus.data_address_2DC[4:2];
  assign req       = bus.read_2DC | bus.write_2DC;
  assign last_line = (scan_set_q == IDX_W'(NUM_SETS - 1)) && (NUM_WAYS == 1 || scan_way_q);

  always_comb begin
    idx     = req_idx;
    sel_way = vway_q;
    case (state_q)
      WB, FILL:             idx = lat_blk_q[IDX_W-1:0];
      FLUSH_SCAN, FLUSH_WB: begin
        idx     = scan_set_q;
        sel_way = scan_way_q;
      end
      default: ;
    endcase
  end

  dcache_tag_store #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_tags (
    .clk(CLK), .rst_n(RESET), .idx(idx), .lk_tag(req_tag), .sel_way(sel_way), .op_way(op_way),
    .op_touch(op_touch), .op_dirty(op_dirty), .op_fill(op_fill),
    .fill_tag(lat_blk_q[ADDR_W-OFFSET_W-1 -: TAG_W]), .op_clean(op_clean), .op_inval(op_inval),
    .hit(hit), .hit_way(hit_way), .vict_way(vict_way), .vict_dirty(vict_dirty),
    .sel_tag(sel_tag), .sel_dirty(sel_dirty)
  );

  assign cur_word = data_arr[req_idx][hit_way][{req_word, 5'd0} +: 32];
  assign wr_word  = merge_bytes(cur_word, bus.data_address_2DC[1:0], bus.data_write_size_2DC,
                                bus.data_write_2DC);

  always_comb begin
    state_n              = state_q;
    bus.data_read_fDC    = '0;
    bus.data_valid_fDC   = 1'b0;
    bus.flush_done_fDC   = 1'b0;
    bus.data_address_2DM = '0;
    bus.dBlkRead         = 1'b0;
    bus.dBlkWrite        = 1'b0;
    bus.block_write_2DM  = '0;
    op_way   = sel_way;
    op_touch = 1'b0;
    op_dirty = 1'b0;
    op_fill  = 1'b0;
    op_clean = 1'b0;
    op_inval = 1'b0;
    hit_svc  = 1'b0;
    hit_wr   = 1'b0;
    fill_we  = 1'b0;
    latch    = 1'b0;
    scan_adv = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush_2DC) begin
          state_n = FLUSH_SCAN;
        end else if (req && hit) begin
          hit_svc            = 1'b1;
          hit_wr             = bus.write_2DC;
          bus.data_valid_fDC = 1'b1;
          bus.data_read_fDC  = cur_word;
          op_way             = hit_way;
          op_touch           = 1'b1;
          op_dirty           = bus.write_2DC;
        end else if (req) begin
          latch   = 1'b1;
          state_n = vict_dirty ? WB : FILL;
        end
      end
      WB, FLUSH_WB: begin
        bus.dBlkWrite        = 1'b1;
        bus.data_address_2DM = {sel_tag, idx, OFFSET_W'(0)};
        bus.block_write_2DM  = data_arr[idx][sel_way];
        if (bus.block_write_fDM_valid) begin
          op_clean = 1'b1;
          state_n  = (state_q == WB) ? FILL : FLUSH_SCAN;
        end
      end
      FILL: begin
        bus.dBlkRead         = 1'b1;
        bus.data_address_2DM = {lat_blk_q, OFFSET_W'(0)};
        if (bus.block_read_fDM_valid) begin
          op_fill = 1'b1;
          fill_we = 1'b1;
          state_n = IDLE;
        end
      end
      FLUSH_SCAN: begin
        if (sel_dirty) begin
          state_n = FLUSH_WB;
        end else begin
          op_inval = 1'b1;
          scan_adv = 1'b1;
          if (last_line) state_n = FLUSH_DONE;
        end
      end
      FLUSH_DONE: begin
        bus.flush_done_fDC = 1'b1;
        if (!bus.flush_2DC) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      scan_set_q <= '0;
      scan_way_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if (state_q == IDLE) begin
        scan_set_q <= '0;
        scan_way_q <= 1'b0;
      end else if (scan_adv) begin
        if (NUM_WAYS == 1 || scan_way_q) begin
          scan_way_q <= 1'b0;
          scan_set_q <= scan_set_q + 1'b1;
        end else begin
          scan_way_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (latch) begin
      lat_blk_q <= bus.data_address_2DC[ADDR_W-1:OFFSET_W];
      vway_q    <= vict_way;
    end
    if (hit_wr)  data_arr[req_idx][hit_way][{req_word, 5'd0} +: 32] <= wr_word;
    if (fill_we) data_arr[idx][vway_q] <= bus.block_read_fDM;
  end

`ifdef DCACHE_STATS_EN
  // The hit that replays a just-filled request belongs to that miss, not to the hit count.
  logic replay_q;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_count  <= '0;
      miss_count <= '0;
      replay_q   <= 1'b0;
    end else begin
      replay_q <= fill_we;
      if (hit_svc && !replay_q && hit_count != '1) hit_count <= hit_count + 1'b1;
      if (latch && miss_count != '1) miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule
